// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table: counter encodings,
// allocation value and the per-entry record.
package bht_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam ctr_e CTR_ALLOC = WT;

    localparam int unsigned DEF_IDX_W  = 3;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned TAG_W      = DEF_ADDR_W - DEF_IDX_W;

    // Entry tags are stored zero-extended to this width so the record type can
    // live here independent of the table's parameters.
    localparam int unsigned TAG_MAX_W = 32;

    function automatic int unsigned tagWidth(input int unsigned addrW, input int unsigned idxW);
        return addrW - idxW;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        ctr_e                 ctr;
        logic [31:0]          target;
    } entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import bht_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctrNext
);

    always_comb begin
        ctrNext = ctr;
        if (taken) begin
            if (ctr != ST) ctrNext = ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) ctrNext = ctr_e'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Direct-mapped, flop-based branch history table with 2-bit hysteresis counters
// and saturating branch / mispredict statistics.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred,
    input  logic              clear,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int unsigned Entries = 2 ** IDX_W;
    localparam int unsigned TagW    = tagWidth(ADDR_W, IDX_W);

    entry_t tableQ [Entries];
    entry_t tableD [Entries];

    logic [IDX_W-1:0]     lkIdx, updIdx;
    logic [TAG_MAX_W-1:0] lkTag, updTag;
    logic                 lkHit, updHit;
    ctr_e                 ctrNext;
    logic [CNT_W-1:0]     branchCntQ, mispredCntQ;

    assign lkIdx  = lk_pc[IDX_W-1:0];
    assign updIdx = upd_pc[IDX_W-1:0];
    assign lkTag  = TAG_MAX_W'(lk_pc[IDX_W +: TagW]);
    assign updTag = TAG_MAX_W'(upd_pc[IDX_W +: TagW]);

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign lkHit       = tableQ[lkIdx].valid && (tableQ[lkIdx].tag == lkTag);
    assign pred_taken  = lkHit && tableQ[lkIdx].ctr[1];
    assign pred_target = pred_taken ? tableQ[lkIdx].target : 32'd0;

    assign updHit = tableQ[updIdx].valid && (tableQ[updIdx].tag == updTag);

    sat_counter2 u_sat_counter2 (
        .ctr     (tableQ[updIdx].ctr),
        .taken   (upd_taken),
        .ctrNext (ctrNext)
    );

    always_comb begin
        tableD = tableQ;
        if (clear) begin
            for (int i = 0; i < Entries; i++) tableD[i].valid = 1'b0;
        end else if (upd_valid) begin
            if (updHit) begin
                tableD[updIdx].ctr = ctrNext;
                if (upd_taken) tableD[updIdx].target = upd_target;
            end else if (upd_taken) begin
                tableD[updIdx].valid  = 1'b1;
                tableD[updIdx].tag    = updTag;
                tableD[updIdx].ctr    = CTR_ALLOC;
                tableD[updIdx].target = upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Entries; i++) tableQ[i] <= '0;
        end else begin
            tableQ <= tableD;
        end
    end

    // Statistics count every resolved branch, including ones dropped by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branchCntQ  <= '0;
            mispredCntQ <= '0;
        end else if (upd_valid) begin
            if (branchCntQ != '1) branchCntQ <= branchCntQ + CNT_W'(1);
            if ((upd_pred != upd_taken) && (mispredCntQ != '1)) begin
                mispredCntQ <= mispredCntQ + CNT_W'(1);
            end
        end
    end

    assign branch_cnt  = branchCntQ;
    assign mispred_cnt = mispredCntQ;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed, table-driven check of the branch history table plus hand-written
// reset-during-update and counter-saturation sequences.
module tb_branch_history_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  lkPc = '0;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        updValid = 1'b0;
    logic [9:0]  updPc = '0;
    logic        updTaken = 1'b0;
    logic [31:0] updTarget = '0;
    logic        updPred = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] branchCnt, mispredCnt;

    logic        u2Valid = 1'b0;
    logic        u2Taken = 1'b0;
    logic        u2Pred = 1'b0;
    logic        p2Taken;
    logic [31:0] p2Target;
    logic [3:0]  b2Cnt, m2Cnt;

    int nVec = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    branch_history_table dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lk_pc       (lkPc),
        .pred_taken  (predTaken),
        .pred_target (predTarget),
        .upd_valid   (updValid),
        .upd_pc      (updPc),
        .upd_taken   (updTaken),
        .upd_target  (updTarget),
        .upd_pred    (updPred),
        .clear       (clr),
        .branch_cnt  (branchCnt),
        .mispred_cnt (mispredCnt)
    );

    branch_history_table #(.CNT_W(4)) dutSat (
        .clk         (clk),
        .rst_n       (rst_n),
        .lk_pc       (10'h00D),
        .pred_taken  (p2Taken),
        .pred_target (p2Target),
        .upd_valid   (u2Valid),
        .upd_pc      (10'h00D),
        .upd_taken   (u2Taken),
        .upd_target  (32'h0000_0040),
        .upd_pred    (u2Pred),
        .clear       (1'b0),
        .branch_cnt  (b2Cnt),
        .mispred_cnt (m2Cnt)
    );

    typedef struct {
        logic [9:0]  lk;
        logic        uv;
        logic [9:0]  up;
        logic        ut;
        logic [31:0] utgt;
        logic        upr;
        logic        clr;
        logic        et;
        logic [31:0] etgt;
        int          eb;
        int          em;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic [9:0] lk, input logic uv, input logic [9:0] up,
                                input logic ut, input logic [31:0] utgt, input logic upr,
                                input logic c, input logic et, input logic [31:0] etgt,
                                input int eb, input int em);
        vec_t v;
        v.lk = lk; v.uv = uv; v.up = up; v.ut = ut; v.utgt = utgt; v.upr = upr;
        v.clr = c; v.et = et; v.etgt = etgt; v.eb = eb; v.em = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // Expected values are the pre-update state seen during each vector's cycle.
        vecs[0]  = mk(10'h005, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000,  0,  0);
        vecs[1]  = mk(10'h00D, 1, 10'h00D, 1, 32'h40, 0, 0, 0, 32'h000,  0,  0);
        vecs[2]  = mk(10'h00D, 0, 10'h000, 0, 32'h00, 0, 0, 1, 32'h040,  1,  1);
        vecs[3]  = mk(10'h00D, 1, 10'h00D, 0, 32'h00, 1, 0, 1, 32'h040,  1,  1);
        vecs[4]  = mk(10'h00D, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000,  2,  2);
        vecs[5]  = mk(10'h00D, 1, 10'h00D, 1, 32'h44, 0, 0, 0, 32'h000,  2,  2);
        vecs[6]  = mk(10'h00D, 1, 10'h00D, 1, 32'h44, 1, 0, 1, 32'h044,  3,  3);
        vecs[7]  = mk(10'h00D, 1, 10'h00D, 0, 32'h00, 1, 0, 1, 32'h044,  4,  3);
        vecs[8]  = mk(10'h00D, 1, 10'h00D, 0, 32'h00, 1, 0, 1, 32'h044,  5,  4);
        vecs[9]  = mk(10'h00D, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000,  6,  5);
        vecs[10] = mk(10'h00D, 1, 10'h00D, 1, 32'h48, 0, 0, 0, 32'h000,  6,  5);
        vecs[11] = mk(10'h00D, 1, 10'h00D, 1, 32'h48, 1, 0, 1, 32'h048,  7,  6);
        vecs[12] = mk(10'h00D, 1, 10'h00D, 1, 32'h48, 1, 0, 1, 32'h048,  8,  6);
        vecs[13] = mk(10'h00D, 1, 10'h00D, 0, 32'h00, 1, 0, 1, 32'h048,  9,  6);
        vecs[14] = mk(10'h00D, 1, 10'h00D, 0, 32'h00, 1, 0, 1, 32'h048, 10,  7);
        vecs[15] = mk(10'h00D, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000, 11,  8);
        vecs[16] = mk(10'h015, 1, 10'h015, 0, 32'h00, 0, 0, 0, 32'h000, 11,  8);
        vecs[17] = mk(10'h015, 1, 10'h015, 1, 32'h80, 0, 0, 0, 32'h000, 12,  8);
        vecs[18] = mk(10'h00D, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000, 13,  9);
        vecs[19] = mk(10'h015, 0, 10'h000, 0, 32'h00, 0, 0, 1, 32'h080, 13,  9);
        vecs[20] = mk(10'h003, 1, 10'h003, 1, 32'h3FF, 1, 0, 0, 32'h000, 13, 9);
        vecs[21] = mk(10'h003, 0, 10'h000, 0, 32'h00, 0, 0, 1, 32'h3FF, 14,  9);
        vecs[22] = mk(10'h015, 0, 10'h000, 0, 32'h00, 0, 0, 1, 32'h080, 14,  9);
        vecs[23] = mk(10'h203, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000, 14,  9);
        vecs[24] = mk(10'h003, 1, 10'h00D, 1, 32'h55, 0, 1, 1, 32'h3FF, 14,  9);
        vecs[25] = mk(10'h003, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000, 15, 10);
        vecs[26] = mk(10'h00D, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000, 15, 10);
        vecs[27] = mk(10'h015, 0, 10'h000, 0, 32'h00, 0, 0, 0, 32'h000, 15, 10);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            lkPc = vecs[i].lk; updValid = vecs[i].uv; updPc = vecs[i].up;
            updTaken = vecs[i].ut; updTarget = vecs[i].utgt; updPred = vecs[i].upr;
            clr = vecs[i].clr;
            #1;
            check($sformatf("v%0d pred_taken", i), 32'(predTaken), 32'(vecs[i].et));
            check($sformatf("v%0d pred_target", i), predTarget, vecs[i].etgt);
            check($sformatf("v%0d branch_cnt", i), 32'(branchCnt), 32'(vecs[i].eb));
            check($sformatf("v%0d mispred_cnt", i), 32'(mispredCnt), 32'(vecs[i].em));
        end

        // Allocate 0x00D, then assert reset mid-cycle while another update is pending.
        @(negedge clk);
        lkPc = 10'h00D; updValid = 1'b1; updPc = 10'h00D; updTaken = 1'b1;
        updTarget = 32'h77; updPred = 1'b0; clr = 1'b0;
        @(negedge clk);
        #1;
        check("realloc pred_taken", 32'(predTaken), 32'd1);
        check("realloc pred_target", predTarget, 32'h77);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst branch_cnt", 32'(branchCnt), 32'd0);
        check("async rst mispred_cnt", 32'(mispredCnt), 32'd0);
        check("async rst pred_taken", 32'(predTaken), 32'd0);
        @(negedge clk);
        updValid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post rst pred_taken", 32'(predTaken), 32'd0);
        check("post rst pred_target", predTarget, 32'd0);
        check("post rst branch_cnt", 32'(branchCnt), 32'd0);
        @(negedge clk);
        #1;
        check("post rst settled pred_taken", 32'(predTaken), 32'd0);

        // 4-bit statistics saturate at 15 rather than wrapping.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            u2Valid = 1'b1; u2Taken = 1'b1; u2Pred = 1'b0;
            #1;
            if (i == 14) check("sat mispred after 14", 32'(m2Cnt), 32'd14);
        end
        @(negedge clk);
        u2Valid = 1'b0;
        #1;
        check("sat mispred_cnt", 32'(m2Cnt), 32'd15);
        check("sat branch_cnt", 32'(b2Cnt), 32'd15);
        check("sat entry pred_taken", 32'(p2Taken), 32'd1);
        check("sat entry pred_target", p2Target, 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
